// File: rtl/if_fetch_bpred_pkg.sv
// Shared definitions for the IF stage: the branch opcode, the 2-bit counter
// encodings and their reset value, plus small decode/update helpers.
package if_fetch_bpred_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not-taken
    CTR_WNT = 2'b01,  // weakly not-taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_e;

  localparam ctr_e BHT_RESET_VAL = CTR_WNT;

  // B-type immediate: sext({d[31], d[7], d[30:25], d[11:8], 1'b0})
  function automatic logic [31:0] imm_b(input logic [31:0] d);
    return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
  endfunction

  // Saturating 2-bit counter step toward the resolved outcome
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    logic [1:0] v;
    v = c;
    if (taken && (v != 2'b11)) begin
      v = v + 2'd1;
    end else if (!taken && (v != 2'b00)) begin
      v = v - 2'd1;
    end
    return ctr_e'(v);
  endfunction

endpackage

// File: rtl/if_fetch_bpred_bht_2bit.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port (fetch) and one synchronous update port (EX resolve).
// A read of an entry being updated in the same cycle returns the old value.
module bht_2bit
  import if_fetch_bpred_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output ctr_e             o_rd_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  ctr_e r_ctr [ENTRIES];

  assign o_rd_ctr = r_ctr[i_rd_idx];

  // Counter array: async clear to weakly-not-taken, saturating update per resolved branch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the table is reset explicitly so learned history is discarded on reset; this keeps it in flops rather than RAM, and state uses <= so all entries update together at the edge.
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= BHT_RESET_VAL;
      end
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/if_fetch_bpred.sv
// IF stage: PC register, B-type predecode, BHT-based prediction and the
// next-PC selection (EX mispredict > stall > ID jump > predicted taken > +4).
module if_fetch_bpred
  import if_fetch_bpred_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BHT_ENTRIES = 64,
  parameter int          BHT_IDX_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_mem_read_data,
  output logic [31:0] inst_mem_read_addr,
  output logic        IF_take,
  input  logic        EX_stall,
  input  logic        ID_branch,
  input  logic [31:0] ID_target,
  input  logic        EX_branch,
  input  logic        EX_zero,
  input  logic        EX_take,
  input  logic [31:0] EX_pc,
  input  logic [31:0] EX_target
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_pred_target;
  logic        w_is_b;
  logic        w_mispred;
  ctr_e        w_rd_ctr;
  logic        w_unused_bits;

  // Predecode: only the opcode decides B-type; register/funct3 fields are ignored
  assign w_is_b        = (inst_mem_read_data[6:0] == OPC_BRANCH);
  assign w_pred_target = r_pc + imm_b(inst_mem_read_data);
  assign IF_take       = w_is_b && w_rd_ctr[1];
  assign w_mispred     = EX_branch && (EX_zero != EX_take);

  assign inst_mem_read_addr = r_pc;
  assign w_unused_bits      = ^{inst_mem_read_data[24:12], w_rd_ctr[0]};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (BHT_IDX_W)
  ) u_bht (
    .clk         (clk),
    .reset       (reset),
    .i_rd_idx    (r_pc[BHT_IDX_W+1:2]),
    .o_rd_ctr    (w_rd_ctr),
    .i_upd_en    (EX_branch),
    .i_upd_idx   (EX_pc[BHT_IDX_W+1:2]),
    .i_upd_taken (EX_zero)
  );

  // Next-PC priority mux
  always_comb begin
    // NOTE: default assignment first so every path drives w_next_pc (no latch); blocking = is correct in combinational logic.
    w_next_pc = r_pc + 32'd4;
    if (w_mispred) begin
      w_next_pc = EX_zero ? EX_target : (EX_pc + 32'd4);
    end else if (EX_stall) begin
      w_next_pc = r_pc;
    end else if (ID_branch) begin
      w_next_pc = ID_target;
    end else if (IF_take) begin
      w_next_pc = w_pred_target;
    end
  end

  // PC register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_bpred.sv
// Directed bench for if_fetch_bpred. The stimulus thread queues the expected
// fetch address and IF_take for each cycle; a monitor thread compares them
// mid-cycle (falling edge) against the DUT.
module tb_if_fetch_bpred;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] BEQ_P32 = 32'h0200_0063;  // beq x0,x0,+32 at 0x10
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;  // beq x0,x0,-8  at 0x08

  logic        clk;
  logic        reset;
  logic [31:0] inst_mem_read_data;
  logic [31:0] inst_mem_read_addr;
  logic        IF_take;
  logic        EX_stall;
  logic        ID_branch;
  logic [31:0] ID_target;
  logic        EX_branch;
  logic        EX_zero;
  logic        EX_take;
  logic [31:0] EX_pc;
  logic [31:0] EX_target;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        take;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  if_fetch_bpred #(
    .RESET_PC    (32'h0),
    .BHT_ENTRIES (64),
    .BHT_IDX_W   (6)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .inst_mem_read_data (inst_mem_read_data),
    .inst_mem_read_addr (inst_mem_read_addr),
    .IF_take            (IF_take),
    .EX_stall           (EX_stall),
    .ID_branch          (ID_branch),
    .ID_target          (ID_target),
    .EX_branch          (EX_branch),
    .EX_zero            (EX_zero),
    .EX_take            (EX_take),
    .EX_pc              (EX_pc),
    .EX_target          (EX_target)
  );

  // Combinational instruction memory: two branches, NOPs elsewhere
  assign inst_mem_read_data = (inst_mem_read_addr == 32'h10) ? BEQ_P32 :
                              (inst_mem_read_addr == 32'h08) ? BEQ_M8  : NOP;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare one queued expectation per cycle at the falling edge
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".addr"}, inst_mem_read_addr, e.addr);
        check({e.name, ".take"}, {31'd0, IF_take}, {31'd0, e.take});
      end
    end
  end

  // Queue the expectation for the current cycle, then advance one cycle
  task automatic step(input string name, input logic [31:0] a, input logic t);
    sb.push_back('{name, a, t});
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    EX_stall  = 1'b0;
    ID_branch = 1'b0;
    ID_target = 32'h0;
    EX_branch = 1'b0;
    EX_zero   = 1'b0;
    EX_take   = 1'b0;
    EX_pc     = 32'h0;
    EX_target = 32'h0;
  endtask

  // Correctly predicted resolve (no redirect) that trains the counter at pc
  task automatic ex_upd(input string name, input logic [31:0] a, input logic t,
                        input logic [31:0] pc, input logic taken);
    EX_branch = 1'b1;
    EX_zero   = taken;
    EX_take   = taken;
    EX_pc     = pc;
    step(name, a, t);
    clr();
  endtask

  task automatic jump(input string name, input logic [31:0] a, input logic [31:0] tgt);
    ID_branch = 1'b1;
    ID_target = tgt;
    step(name, a, 1'b0);
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: sequential fetch after reset
    step("t1_a00", 32'h00, 1'b0);
    step("t1_a04", 32'h04, 1'b0);
    step("t1_a08", 32'h08, 1'b0);  // backward beq, untrained
    step("t1_a0c", 32'h0C, 1'b0);

    // 2: untrained beq, then EX mispredict trains 01->10 and redirects
    step("t2_beq_untrained", 32'h10, 1'b0);
    EX_branch = 1'b1; EX_zero = 1'b1; EX_take = 1'b0;
    EX_pc = 32'h10; EX_target = 32'h30;
    step("t2_mispred", 32'h14, 1'b0);
    clr();
    step("t2_redirect", 32'h30, 1'b0);

    // 3: trained beq predicts taken
    jump("t3_jump", 32'h34, 32'h10);
    step("t3_beq_trained", 32'h10, 1'b1);
    step("t3_pred_target", 32'h30, 1'b0);
    // five decrements (10->01->00->00->00->00), one increment -> 01
    ex_upd("t3_dec1", 32'h34, 1'b0, 32'h10, 1'b0);
    ex_upd("t3_dec2", 32'h38, 1'b0, 32'h10, 1'b0);
    ex_upd("t3_dec3", 32'h3C, 1'b0, 32'h10, 1'b0);
    ex_upd("t3_dec4", 32'h40, 1'b0, 32'h10, 1'b0);
    ex_upd("t3_dec5", 32'h44, 1'b0, 32'h10, 1'b0);
    ex_upd("t3_inc1", 32'h48, 1'b0, 32'h10, 1'b1);
    jump("t3_jump2", 32'h4C, 32'h10);
    step("t3_sat_low", 32'h10, 1'b0);
    // three increments (01->10->11->11), one decrement -> 10
    ex_upd("t3_inc2", 32'h14, 1'b0, 32'h10, 1'b1);
    ex_upd("t3_inc3", 32'h18, 1'b0, 32'h10, 1'b1);
    ex_upd("t3_inc4", 32'h1C, 1'b0, 32'h10, 1'b1);
    ex_upd("t3_dec6", 32'h20, 1'b0, 32'h10, 1'b0);
    jump("t3_jump3", 32'h24, 32'h10);
    step("t3_sat_high", 32'h10, 1'b1);
    // same-cycle read and update: prediction uses the old counter (10)
    jump("t3_jump4", 32'h30, 32'h10);
    ex_upd("t3_same_cycle_old", 32'h10, 1'b1, 32'h10, 1'b0);
    jump("t3_jump5", 32'h30, 32'h10);
    step("t3_same_cycle_new", 32'h10, 1'b0);

    // 4: mispredict beats stall and ID jump; stall holds; stall beats ID jump
    EX_branch = 1'b1; EX_zero = 1'b0; EX_take = 1'b1;
    EX_pc = 32'h100; EX_target = 32'h400;
    EX_stall = 1'b1; ID_branch = 1'b1; ID_target = 32'h200;
    step("t4_all_at_once", 32'h14, 1'b0);
    clr();
    EX_stall = 1'b1;
    step("t4_stall1", 32'h104, 1'b0);
    step("t4_stall2", 32'h104, 1'b0);
    step("t4_stall3", 32'h104, 1'b0);
    ID_branch = 1'b1; ID_target = 32'h200;
    step("t4_stall_vs_id", 32'h104, 1'b0);
    clr();
    step("t4_after_stall", 32'h104, 1'b0);
    EX_branch = 1'b1; EX_zero = 1'b1; EX_take = 1'b0;
    EX_pc = 32'h100; EX_target = 32'h500;
    step("t4_mispred_taken", 32'h108, 1'b0);
    clr();

    // 5: train backward branch at 0x8, PC wrap, backward predicted target
    ex_upd("t5_train1", 32'h500, 1'b0, 32'h08, 1'b1);
    ex_upd("t5_train2", 32'h504, 1'b0, 32'h08, 1'b1);
    jump("t5_jump_top", 32'h508, 32'hFFFF_FFFC);
    step("t5_wrap", 32'hFFFF_FFFC, 1'b0);
    step("t5_a00", 32'h00, 1'b0);
    step("t5_a04", 32'h04, 1'b0);
    step("t5_backward", 32'h08, 1'b1);
    step("t5_back_target", 32'h00, 1'b0);
    step("t5_a04b", 32'h04, 1'b0);

    // 6: asynchronous reset with PC at the trained backward branch
    reset = 1'b1;
    #1;
    sb.push_back('{"t6_async_reset", 32'h0, 1'b0});
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("t6_a00", 32'h00, 1'b0);
    step("t6_a04", 32'h04, 1'b0);
    step("t6_bk_untrained", 32'h08, 1'b0);
    step("t6_a0c", 32'h0C, 1'b0);
    step("t6_beq", 32'h10, 1'b0);
    step("t6_a14", 32'h14, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
